// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: synchronise, debounce on prescaler ticks,
// and emit a clean level plus press / release / long-press pulses per channel.
module btn_debounce #(
    parameter int unsigned      N_BTN        = 4,
    parameter int unsigned      STABLE_TICKS = 3,
    parameter int unsigned      LONG_TICKS   = 10,
    parameter logic [N_BTN-1:0] INVERT       = {N_BTN{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int unsigned CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS);

    logic [N_BTN-1:0]  s1_q, s2_q;
    logic [CNT_W-1:0]  cnt_q  [N_BTN];
    logic [CNT_W-1:0]  cnt_d  [N_BTN];
    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [HOLD_W-1:0] hold_d [N_BTN];
    logic [N_BTN-1:0]  level_q, level_d;
    logic [N_BTN-1:0]  long_done_q, long_done_d;
    logic [N_BTN-1:0]  press_q, press_d;
    logic [N_BTN-1:0]  release_q, release_d;
    logic [N_BTN-1:0]  long_q, long_d;

    always_comb begin
        level_d     = level_q;
        long_done_d = long_done_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt_d[i]  = cnt_q[i];
            hold_d[i] = hold_q[i];
            if (tick) begin
                if (s2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        level_d[i]   = s2_q[i];
                        cnt_d[i]     = '0;
                        press_d[i]   = s2_q[i];
                        release_d[i] = ~s2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end

                // A release accepted on the same tick overrides any long-press completion.
                if (release_d[i]) begin
                    hold_d[i]      = '0;
                    long_done_d[i] = 1'b0;
                end else if (level_q[i] && !long_done_q[i]) begin
                    hold_d[i] = hold_q[i] + 1'b1;
                    if (hold_d[i] == HOLD_LAST) begin
                        long_d[i]      = 1'b1;
                        long_done_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            level_q     <= '0;
            long_done_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            s1_q        <= btn_raw ^ INVERT;
            s2_q        <= s1_q;
            level_q     <= level_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus randomized chatter, checked
// every cycle against a tick-counting reference model.
module tb_btn_debounce;

    localparam int unsigned N      = 4;
    localparam int unsigned STABLE = 3;
    localparam int unsigned LONG   = 8;
    localparam logic [N-1:0] INV   = 4'b1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    btn_debounce #(
        .N_BTN       (N),
        .STABLE_TICKS(STABLE),
        .LONG_TICKS  (LONG),
        .INVERT      (INV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: pressed-sense pipeline plus run / hold tick counts
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
    int           m_run  [N];
    int           m_held [N];

    int tick_per = 4;
    int tick_ph  = 0;
    int press_cnt [N];
    int rel_cnt   [N];
    int long_cnt  [N];
    logic simul_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [N-1:0] smp;
        logic         old_lvl, rel;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0;
                m_held[i] = 0;
            end
        end else begin
            smp = m_s2;
            m_press = '0; m_rel = '0; m_long = '0;
            if (tick) begin
                for (int i = 0; i < N; i++) begin
                    old_lvl = m_level[i];
                    rel = 1'b0;
                    if (smp[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == STABLE) begin
                            m_level[i] = smp[i];
                            m_run[i] = 0;
                            if (smp[i]) m_press[i] = 1'b1;
                            else begin
                                m_rel[i] = 1'b1;
                                rel = 1'b1;
                            end
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    if (rel) m_held[i] = 0;
                    else if (old_lvl) begin
                        m_held[i]++;
                        if (m_held[i] == LONG) m_long[i] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw ^ INV;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i] = 0;
            long_cnt[i] = 0;
        end
        simul_seen = 1'b0;
    endtask

    // one clk cycle: drive on negedge, model at posedge, compare 1 time unit later
    task automatic step(input logic [N-1:0] pressed, input logic r, output logic ticked);
        @(negedge clk);
        tick    = (tick_ph == 0);
        tick_ph = (tick_ph + 1) % tick_per;
        rst     = r;
        btn_raw = pressed ^ INV;
        ticked  = tick;
        @(posedge clk);
        model_update();
        #1;
        check_eq("level",   32'(btn_level),   32'(m_level));
        check_eq("press",   32'(btn_press),   32'(m_press));
        check_eq("release", 32'(btn_release), 32'(m_rel));
        check_eq("long",    32'(btn_long),    32'(m_long));
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   press_cnt[i]++;
            if (btn_release[i]) rel_cnt[i]++;
            if (btn_long[i])    long_cnt[i]++;
        end
        if (btn_release[0] && btn_press[1]) simul_seen = 1'b1;
    endtask

    task automatic tick_steps(input logic [N-1:0] pressed, input int n);
        int   t;
        logic tk;
        t = 0;
        while (t < n) begin
            step(pressed, 1'b0, tk);
            if (tk) t++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         tk;
        logic [N-1:0] p, target;
        int           chat [N];

        clear_counts();
        tick = 1'b1;
        btn_raw = INV;
        for (int i = 0; i < 3; i++) step('0, 1'b1, tk);
        check_eq("rst_level", 32'(btn_level), 0);
        check_eq("rst_pulses", 32'({btn_press, btn_release, btn_long}), 0);
        tick_steps('0, 3);

        // clean press on ch0
        clear_counts();
        tick_steps(4'b0001, 20);
        check_eq("ch0_press_cnt", press_cnt[0], 1);
        check_eq("ch0_level", 32'(btn_level[0]), 1);
        check_eq("others_press", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // bounce on ch1 must be discarded
        clear_counts();
        tick_steps(4'b0011, 2);
        tick_steps(4'b0001, 1);
        tick_steps(4'b0011, 2);
        tick_steps(4'b0001, 3);
        check_eq("bounce_level", 32'(btn_level[1]), 0);
        check_eq("bounce_pulses", press_cnt[1] + rel_cnt[1], 0);

        // ch0 release and ch1 press accepted together
        tick_steps(4'b0010, 4);
        check_eq("simul_seen", 32'(simul_seen), 1);
        check_eq("simul_rel0", rel_cnt[0], 1);
        check_eq("simul_press1", press_cnt[1], 1);

        // long press on ch2, twice
        clear_counts();
        tick_steps(4'b0110, 15);
        check_eq("long_once", long_cnt[2], 1);
        tick_steps(4'b0010, 4);
        check_eq("long_rel", rel_cnt[2], 1);
        tick_steps(4'b0110, 15);
        check_eq("long_twice", long_cnt[2], 2);
        check_eq("long_press2", press_cnt[2], 2);

        // active-low ch3
        clear_counts();
        tick_steps(4'b1110, 4);
        check_eq("inv_press", press_cnt[3], 1);
        check_eq("inv_level", 32'(btn_level[3]), 1);
        tick_steps('0, 5);

        // reset while ch0 is held mid-count
        tick_steps(4'b0001, 8);
        step(4'b0001, 1'b1, tk);
        check_eq("midrst_level", 32'(btn_level), 0);
        clear_counts();
        tick_steps(4'b0001, 12);
        check_eq("repress_cnt", press_cnt[0], 1);
        check_eq("repress_long", long_cnt[0], 1);

        // tick stuck high with chatter
        tick_per = 1; tick_ph = 0;
        for (int i = 0; i < 6; i++) step(4'(i % 2), 1'b0, tk);
        tick_steps('0, 12);

        // randomized chatter, tick rate and occasional reset
        target = '0;
        for (int i = 0; i < N; i++) chat[i] = 0;
        for (int c = 0; c < 5000; c++) begin
            if (c % 250 == 0) begin
                tick_per = $urandom_range(1, 5);
                tick_ph = 0;
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 59) == 0) begin
                    target[i] = ~target[i];
                    chat[i] = $urandom_range(0, 12);
                end
                if (chat[i] > 0) begin
                    p[i] = 1'($urandom_range(0, 1));
                    chat[i]--;
                end else begin
                    p[i] = target[i];
                end
            end
            step(p, ($urandom_range(0, 999) == 0), tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
